// File: rtl/alu_io_pkg.sv
// Shared constants for the ALU front-panel I/O slice.
//   N_BTN            : number of push-button channels
//   CH_A/CH_B/CH_OP  : channel index of the load-A, load-B and load-Op buttons
//   DEBOUNCE_DEFAULT : default debounce interval (10 ms at 100 MHz)
//   lowest_set()     : one-hot isolate of the lowest set bit (fixed-priority grant)
package alu_io_pkg;

   localparam int unsigned N_BTN            = 3;
   localparam int unsigned CH_A             = 0;
   localparam int unsigned CH_B             = 1;
   localparam int unsigned CH_OP            = 2;
   localparam int unsigned DEBOUNCE_DEFAULT = 1000000;

   // v & -v keeps only the lowest set bit; zero in gives zero out.
   function automatic logic [N_BTN-1:0] lowest_set(input logic [N_BTN-1:0] v);
      lowest_set = v & (~v + N_BTN'(1));
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-flop synchronizer, stability counter and
// debounced level register, plus a combinational rise strobe.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   btn   : raw asynchronous button input
//   level : debounced stable level
//   rise  : high for the single cycle in which level is about to go 0->1
module btn_debounce
   import alu_io_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic level,
   output logic rise
);

   localparam int unsigned          CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1, s2, stable;
   logic [CNT_W-1:0] cnt;
   logic             accept;

   // s2 has disagreed with stable for DEBOUNCE_CYCLES consecutive edges
   // (counter 0..DEBOUNCE_CYCLES-1); any agreeing cycle restarts the count.
   assign accept = (s2 != stable) && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
      end else begin
         s1 <= btn;
         s2 <= s1;
         if (s2 == stable) begin
            cnt <= '0;
         end else if (accept) begin
            stable <= s2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign level = stable;
   assign rise  = accept & s2;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the three ALU load buttons into single-cycle load strobes.
// Each channel is debounced independently; accepted presses are latched as
// pending and then issued one per cycle in index order (A, B, Op).
//   clk       : 100 MHz system clock
//   reset     : asynchronous active-low reset
//   btn[2:0]  : raw buttons, [0]=load A, [1]=load B, [2]=load Op
//   e1/e2/e3  : registered one-cycle load-A / load-B / load-Op pulses
//   btn_level : debounced level per button (LED drive)
module btn_conditioner
   import alu_io_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn,
   output logic             e1,
   output logic             e2,
   output logic             e3,
   output logic [N_BTN-1:0] btn_level
);

   logic [N_BTN-1:0] rise, pending, grant, e_q;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk   (clk),
         .reset (reset),
         .btn   (btn[i]),
         .level (btn_level[i]),
         .rise  (rise[i])
      );
   end

   assign grant = lowest_set(pending);

   // A rise on an already-pending channel just re-sets the same bit, so it
   // merges into one pulse. A granted bit cannot coincide with a new rise on
   // that channel: a second rise needs a full debounced release first.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending <= '0;
         e_q     <= '0;
      end else begin
         pending <= (pending & ~grant) | rise;
         e_q     <= grant;
      end
   end

   assign e1 = e_q[CH_A];
   assign e2 = e_q[CH_B];
   assign e3 = e_q[CH_OP];

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after a posedge, so the next posedge is the
// edge "k" at which s1 first samples them; a pulse is expected to be
// visible after the 7th following posedge (edge k+6).
module tb_btn_conditioner;

   logic       clk;
   logic       reset;
   logic [2:0] btn;
   logic       e1, e2, e3;
   logic [2:0] btn_level;

   int n_asrt = 0;
   int n_fail = 0;
   int n_e1 = 0, n_e2 = 0, n_e3 = 0;

   btn_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .btn       (btn),
      .e1        (e1),
      .e2        (e2),
      .e3        (e3),
      .btn_level (btn_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, sample 1 unit later, check mutual exclusion of the
   // strobes and tally pulses.
   task automatic tick();
      logic [2:0] ev;
      @(posedge clk);
      #1;
      ev = {e3, e2, e1};
      chk("onehot", 8'($countones(ev) <= 1), 8'd1);
      n_e1 += int'(e1);
      n_e2 += int'(e2);
      n_e3 += int'(e3);
   endtask

   task automatic chk_out(input string tag, input logic [2:0] exp_e, input logic [2:0] exp_lvl);
      chk({tag, "_e"},   8'({e3, e2, e1}), 8'(exp_e));
      chk({tag, "_lvl"}, 8'(btn_level),    8'(exp_lvl));
   endtask

   initial begin
      int b1, b2, b3;
      logic [2:0] ee;

      // ---------------- reset state ----------------
      reset = 1'b0;
      btn   = 3'b000;
      #1;
      chk_out("rst0", 3'b000, 3'b000);
      tick(); tick();
      chk_out("rst1", 3'b000, 3'b000);
      reset = 1'b1;
      tick(); tick();

      // ---------------- clean press on A ----------------
      btn = 3'b001;
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk_out("clean", (i == 7) ? 3'b001 : 3'b000, (i >= 6) ? 3'b001 : 3'b000);
      end
      btn = 3'b000;
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk_out("clean_rel", 3'b000, (i >= 6) ? 3'b000 : 3'b001);
      end
      chk("clean_cnt_e1", 8'(n_e1), 8'd1);

      // ---------------- bounce on B ----------------
      b2 = n_e2;
      btn = 3'b010;
      for (int i = 0; i < 3; i++) begin tick(); chk_out("bounce_hi", 3'b000, 3'b000); end
      btn = 3'b000;
      for (int i = 0; i < 2; i++) begin tick(); chk_out("bounce_lo", 3'b000, 3'b000); end
      btn = 3'b010;
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk_out("bounce", (i == 7) ? 3'b010 : 3'b000, (i >= 6) ? 3'b010 : 3'b000);
      end
      btn = 3'b000;
      for (int i = 0; i < 8; i++) tick();
      chk("bounce_cnt_e2", 8'(n_e2 - b2), 8'd1);
      chk("bounce_lvl_end", 8'(btn_level), 8'd0);

      // ---------------- simultaneous press ----------------
      b1 = n_e1; b2 = n_e2; b3 = n_e3;
      btn = 3'b111;
      for (int i = 1; i <= 11; i++) begin
         tick();
         ee = (i == 7) ? 3'b001 : (i == 8) ? 3'b010 : (i == 9) ? 3'b100 : 3'b000;
         chk_out("simul", ee, (i >= 6) ? 3'b111 : 3'b000);
      end
      btn = 3'b000;
      for (int i = 0; i < 8; i++) tick();
      chk("simul_cnt_e1", 8'(n_e1 - b1), 8'd1);
      chk("simul_cnt_e2", 8'(n_e2 - b2), 8'd1);
      chk("simul_cnt_e3", 8'(n_e3 - b3), 8'd1);
      chk("simul_lvl_end", 8'(btn_level), 8'd0);

      // ---------------- hold / release / re-press on Op ----------------
      b3 = n_e3;
      btn = 3'b100;
      for (int i = 1; i <= 50; i++) begin
         tick();
         chk_out("hold", (i == 7) ? 3'b100 : 3'b000, (i >= 6) ? 3'b100 : 3'b000);
      end
      btn = 3'b000;
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk_out("release", 3'b000, (i >= 6) ? 3'b000 : 3'b100);
      end
      btn = 3'b100;
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk_out("repress", (i == 7) ? 3'b100 : 3'b000, (i >= 6) ? 3'b100 : 3'b000);
      end
      btn = 3'b000;
      for (int i = 0; i < 8; i++) tick();
      chk("hold_cnt_e3", 8'(n_e3 - b3), 8'd2);

      // ---------------- reset mid-debounce, button held ----------------
      b1 = n_e1;
      btn = 3'b001;
      tick(); tick();
      reset = 1'b0;
      #1;
      chk_out("rstmid_async", 3'b000, 3'b000);
      for (int i = 0; i < 3; i++) begin tick(); chk_out("rstmid_hold", 3'b000, 3'b000); end
      reset = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk_out("rstmid", (i == 7) ? 3'b001 : 3'b000, (i >= 6) ? 3'b001 : 3'b000);
      end
      chk("rstmid_cnt_e1", 8'(n_e1 - b1), 8'd1);
      btn = 3'b000;
      for (int i = 0; i < 8; i++) tick();

      // ---------------- reset with pulses pending ----------------
      // B and Op become pending at the 6th edge; reset before any issues.
      b2 = n_e2; b3 = n_e3;
      btn = 3'b110;
      for (int i = 0; i < 6; i++) tick();
      btn   = 3'b000;
      reset = 1'b0;
      #1;
      chk_out("rstpend_async", 3'b000, 3'b000);
      tick(); tick();
      reset = 1'b1;
      for (int i = 0; i < 12; i++) begin tick(); chk_out("rstpend", 3'b000, 3'b000); end
      chk("rstpend_cnt_e2", 8'(n_e2 - b2), 8'd0);
      chk("rstpend_cnt_e3", 8'(n_e3 - b3), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 1000000, cycles a synchronized level must stay stable before acceptance (10 ms at 100 MHz); legal range >= 2.
REQ-002 Port: clk  input  1  single system clock, 100 MHz; all state on posedge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 Port: btn  input  3  raw push-buttons, asynchronous; [0]=load A, [1]=load B, [2]=load Op.
REQ-005 Port: e1  output  1  one-cycle load-A pulse to the ALU register stage.
REQ-006 Port: e2  output  1  one-cycle load-B pulse.
REQ-007 Port: e3  output  1  one-cycle load-Op pulse.
REQ-008 Port: btn_level  output  3  debounced stable level per button, for LEDs.

Function
REQ-009 Each btn bit SHALL pass a 2-flop synchronizer (s1, s2) before any other use.
REQ-010 Per channel, a counter SHALL clear whenever s2 equals stable, and increment when they differ.
REQ-011 When s2 differs from stable and the counter equals DEBOUNCE_CYCLES-1, the channel SHALL load stable <= s2 and clear the counter.
REQ-012 A differing run shorter than DEBOUNCE_CYCLES cycles (bounce/glitch) SHALL leave stable unchanged and produce no pulse.
REQ-013 A stable 0->1 update SHALL set pending[i]; a 1->0 update SHALL set nothing.
REQ-014 Each posedge, registered outputs {e3,e2,e1} SHALL take a one-hot vector of the lowest-index set pending bit, or all zero; that bit SHALL clear on the same edge.
REQ-015 At most one of e1/e2/e3 SHALL be high in any cycle; each SHALL be high for exactly one cycle per accepted press.
REQ-016 Simultaneous presses SHALL be served in index order (e1, e2, e3) on consecutive cycles; none lost.
REQ-017 A rise on a channel whose pending bit is already set SHALL merge (single pulse).
REQ-018 Latency: with no contention, let k be the first posedge at which s1 samples the new high level; e_i SHALL be high during the cycle after posedge k+DEBOUNCE_CYCLES+2.
REQ-019 A button held indefinitely SHALL yield exactly one pulse; a new pulse requires a debounced release then press.
REQ-020 btn_level SHALL equal the per-channel stable registers.
REQ-021 A button held high across reset deassertion SHALL be treated as a new press (stable resets to 0) and pulse once after the REQ-018 latency.

Reset
REQ-022 While reset=0, s1, s2, stable, counters, pending, e1, e2, e3 and btn_level SHALL all be 0, asynchronously.
REQ-023 Reset asserted mid-debounce or with pulses pending SHALL discard all in-flight presses; no pulse after deassertion unless re-qualified (REQ-021).

Structure
REQ-024 Shared package alu_io_pkg SHALL hold N_BTN=3, channel index constants (CH_A=0, CH_B=1, CH_OP=2), and the default debounce count.
REQ-025 Sub-module btn_debounce (synchronizer + counter + stable + rise flag, one channel) SHALL be instantiated N_BTN times; arbitration and output registers live in btn_conditioner.
REQ-026 Counter width SHALL be derived from DEBOUNCE_CYCLES; no hard-coded width.

Verification (bench with DEBOUNCE_CYCLES=4)
REQ-027 Clean press: btn[0] 0->1 sampled at edge k, held -> e1 high only during the cycle after edge k+6; e2=e3=0; btn_level=001.
REQ-028 Bounce: btn[1] high 3 cycles, low 2, then high held -> no pulse during bounce; exactly one e2 pulse, 6 edges after the final rise is first sampled.
REQ-029 Simultaneous: btn=111 in one cycle -> e1, e2, e3 each pulse once on three consecutive cycles in that order; never two high together.
REQ-030 Hold/release: btn[2] held 50 cycles, released, re-pressed -> exactly two e3 pulses total; no pulse on release.
REQ-031 Reset mid-op: btn[0] rises, reset=0 asserted 2 cycles later for 3 cycles while btn held -> all outputs 0 during reset; one e1 pulse after REQ-018 latency measured from deassertion.
REQ-032 Every scenario SHALL check per cycle that at most one of e1/e2/e3 is high.
